// File: rtl/fp32_addsub_arb.sv
// Round-robin arbiter sharing one pipelined fp32 add/sub unit among NUM_REQ requesters.
// Optional FP32_ARB_STATS_EN adds per-requester grant counters and a response counter.
module fp32_addsub_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 4,
  parameter int TAG_W   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_arb_en,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic [NUM_REQ*32-1:0]  i_req_dina,
  input  logic [NUM_REQ*32-1:0]  i_req_dinb,
  input  logic [NUM_REQ-1:0]     i_req_op,
  output logic [31:0]            o_add_dina,
  output logic [31:0]            o_add_dinb,
  output logic                   o_add_op,
  output logic                   o_add_valid_in,
  input  logic [31:0]            i_add_result,
  input  logic                   i_add_valid_out,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic                   o_busy,
  output logic                   o_err_spurious
`ifdef FP32_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  o_grant_cnt,
  output logic [15:0]            o_rsp_cnt
`endif
);

  logic [TAG_W-1:0]                r_rr_ptr;
  logic                            r_iss_valid;
  logic [TAG_W-1:0]                r_iss_tag;
  logic [31:0]                     r_add_dina;
  logic [31:0]                     r_add_dinb;
  logic                            r_add_op;
  logic [ADD_LAT-1:0]              r_tag_v;
  logic [ADD_LAT-1:0][TAG_W-1:0]   r_tag_id;
  logic [NUM_REQ-1:0]              r_rsp_valid;
  logic [31:0]                     r_rsp_data;
  logic                            r_err;

  logic [NUM_REQ-1:0]              w_req_ready;
  logic [TAG_W-1:0]                w_gnt_idx;
  logic                            w_grant_any;
  int                              w_idx;
  logic                            w_last_v;
  logic [NUM_REQ-1:0]              w_rsp_onehot;

  always_comb begin
    w_req_ready = '0;
    w_gnt_idx   = '0;
    w_grant_any = 1'b0;
    w_idx       = 0;
    if (i_arb_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
        if (!w_grant_any && i_req_valid[w_idx]) begin
          w_grant_any        = 1'b1;
          w_gnt_idx          = TAG_W'(w_idx);
          w_req_ready[w_idx] = 1'b1;
        end
      end
    end
  end

  assign w_last_v     = r_tag_v[ADD_LAT-1];
  assign w_rsp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_tag_id[ADD_LAT-1];

  // The tag line starts behind the issue register so its last stage lines up with the adder output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_iss_valid <= 1'b0;
      r_iss_tag   <= '0;
      r_add_dina  <= '0;
      r_add_dinb  <= '0;
      r_add_op    <= 1'b0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_iss_valid <= w_grant_any;
      if (w_grant_any) begin
        r_rr_ptr   <= (int'(w_gnt_idx) == NUM_REQ-1) ? '0 : w_gnt_idx + 1'b1;
        r_iss_tag  <= w_gnt_idx;
        r_add_dina <= i_req_dina[32*int'(w_gnt_idx) +: 32];
        r_add_dinb <= i_req_dinb[32*int'(w_gnt_idx) +: 32];
        r_add_op   <= i_req_op[w_gnt_idx];
      end
      r_tag_v  <= {r_tag_v[ADD_LAT-2:0], r_iss_valid};
      r_tag_id <= {r_tag_id[ADD_LAT-2:0], r_iss_tag};
      if (i_add_valid_out && w_last_v) begin
        r_rsp_valid <= w_rsp_onehot;
        r_rsp_data  <= i_add_result;
      end else begin
        r_rsp_valid <= '0;
      end
      if (i_add_valid_out != w_last_v) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_req_ready    = w_req_ready;
  assign o_add_dina     = r_add_dina;
  assign o_add_dinb     = r_add_dinb;
  assign o_add_op       = r_add_op;
  assign o_add_valid_in = r_iss_valid;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_err_spurious = r_err;
  assign o_busy         = r_iss_valid | (|r_tag_v) | (|r_rsp_valid);

`ifdef FP32_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_grant_cnt;
  logic [15:0]              r_rsp_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_cnt <= '0;
      r_rsp_cnt   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_req_ready[i] && r_grant_cnt[i] != 16'hFFFF) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
      if ((|r_rsp_valid) && r_rsp_cnt != 16'hFFFF) begin
        r_rsp_cnt <= r_rsp_cnt + 16'd1;
      end
    end
  end

  assign o_grant_cnt = r_grant_cnt;
  assign o_rsp_cnt   = r_rsp_cnt;
`endif

endmodule

// File: tb/tb_fp32_addsub_arb.sv
// Scoreboard bench for fp32_addsub_arb with a behavioural 4-cycle adder built from a vector table.
// Build with FP32_ARB_STATS_EN defined to also check the statistics counters.
module tb_fp32_addsub_arb;

  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 4;
  localparam int NVEC    = 6;

  // Hand-computed fp32 vectors: 1+2=3, 2+2=4, 3-1=2, 4-1=3, 1+0.5=1.5, 5-4=1
  localparam logic [31:0] VA [NVEC] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                        32'h40800000, 32'h3F800000, 32'h40A00000};
  localparam logic [31:0] VB [NVEC] = '{32'h40000000, 32'h40000000, 32'h3F800000,
                                        32'h3F800000, 32'h3F000000, 32'h40800000};
  localparam logic        VO [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] VR [NVEC] = '{32'h40400000, 32'h40800000, 32'h40000000,
                                        32'h40400000, 32'h3FC00000, 32'h3F800000};

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  arbEn = 1'b0;
  logic [NUM_REQ-1:0]    reqValid = '0;
  logic [NUM_REQ-1:0]    reqReady;
  logic [NUM_REQ*32-1:0] reqDina = '0;
  logic [NUM_REQ*32-1:0] reqDinb = '0;
  logic [NUM_REQ-1:0]    reqOp = '0;
  logic [31:0]           addDina, addDinb, addResult;
  logic                  addOp, addValidIn, addValidOut;
  logic [NUM_REQ-1:0]    rspValid;
  logic [31:0]           rspData;
  logic                  busy, errSpurious;
  logic                  forceSpur = 1'b0;
`ifdef FP32_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grantCnt;
  logic [15:0]           rspCnt;
`endif

  fp32_addsub_arb #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .TAG_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_arb_en(arbEn),
    .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_dina(reqDina), .i_req_dinb(reqDinb), .i_req_op(reqOp),
    .o_add_dina(addDina), .o_add_dinb(addDinb), .o_add_op(addOp),
    .o_add_valid_in(addValidIn), .i_add_result(addResult), .i_add_valid_out(addValidOut),
    .o_rsp_valid(rspValid), .o_rsp_data(rspData),
    .o_busy(busy), .o_err_spurious(errSpurious)
`ifdef FP32_ARB_STATS_EN
    , .o_grant_cnt(grantCnt), .o_rsp_cnt(rspCnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: looks the operand pair up in the vector table, reset together with the arbiter.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    for (int i = 0; i < NVEC; i++)
      if (VA[i] == a && VB[i] == b && VO[i] == op) return VR[i];
    return 32'hDEADBEEF;
  endfunction

  logic [ADD_LAT-1:0] pipeV = '0;
  logic [31:0]        pipeR [ADD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      pipeV <= '0;
    end else begin
      pipeV    <= {pipeV[ADD_LAT-2:0], addValidIn};
      pipeR[0] <= fadd(addDina, addDinb, addOp);
      for (int i = 1; i < ADD_LAT; i++) pipeR[i] <= pipeR[i-1];
    end
  end
  assign addValidOut = pipeV[ADD_LAT-1] | forceSpur;
  assign addResult   = pipeR[ADD_LAT-1];

  typedef struct {
    logic [NUM_REQ-1:0] onehot;
    logic [31:0]        data;
    int                 cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int reqVec [NUM_REQ] = '{0, 1, 2, 3};
  int req0Grants = 0;
  int lastGrantCyc = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response strobe and checks owner, data and arrival cycle.
  always @(posedge clk) begin
    #1;
    if (!rst && rspValid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", rspValid, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_owner", rspValid, e.onehot);
        checkOutput("rsp_data", rspData, e.data);
        checkOutput("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] expReady,
                               input logic en);
    exp_t e;
    @(negedge clk);
    arbEn    = en;
    reqValid = mask;
    for (int r = 0; r < NUM_REQ; r++) begin
      reqDina[32*r +: 32] = VA[reqVec[r]];
      reqDinb[32*r +: 32] = VB[reqVec[r]];
      reqOp[r]            = VO[reqVec[r]];
    end
    #1;
    checkOutput("req_ready", reqReady, expReady);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (expReady[r]) begin
        e.onehot     = NUM_REQ'(1) << r;
        e.data       = VR[reqVec[r]];
        e.cyc        = cyc + ADD_LAT + 2;
        lastGrantCyc = cyc;
        sb.push_back(e);
        if (r == 0) req0Grants++;
      end
    end
  endtask

  task automatic waitUntilCycle(input int target);
    int guard = 0;
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      reqValid = '0;
      guard++;
    end
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    arbEn    = 1'b0;
    reqValid = '0;
    sb.delete();
    req0Grants = 0;
    @(negedge clk);
    #1;
    checkOutput("rst_rsp_valid", rspValid, '0);
    checkOutput("rst_rsp_data", rspData, '0);
    checkOutput("rst_add_valid", addValidIn, '0);
    checkOutput("rst_add_dina", addDina, '0);
    checkOutput("rst_busy", busy, '0);
    checkOutput("rst_err", errSpurious, '0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c;
    repeat (2) @(negedge clk);
    doReset();

    // Single op on requester 0: 1.0 + 2.0
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    c = lastGrantCyc;
    waitUntilCycle(c + 6);
    checkOutput("single_busy_rsp", busy, 1'b1);
    waitUntilCycle(c + 8);
    checkOutput("single_busy_idle", busy, 1'b0);

    // Full contention from reset
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(4'b1111, 4'(1 << (k % 4)), 1'b1);
    waitUntilCycle(cyc + 10);

    // Pointer fairness and wrap: ptr -> 3, then {1,3} gives 3 then 1, then wrap to 0
    reqVec = '{4, 2, 1, 5};
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    applyStimulus(4'b1010, 4'b1000, 1'b1);
    applyStimulus(4'b1010, 4'b0010, 1'b1);
    applyStimulus(4'b1011, 4'b1000, 1'b1);
    applyStimulus(4'b0011, 4'b0001, 1'b1);
    waitUntilCycle(cyc + 10);

    // arb_en drop after four back-to-back grants
    doReset();
    reqVec = '{0, 1, 2, 3};
    for (int k = 0; k < 4; k++) applyStimulus(4'b1111, 4'(1 << k), 1'b1);
    c = lastGrantCyc;
    for (int k = 0; k < 3; k++) applyStimulus(4'b1111, 4'b0000, 1'b0);
    waitUntilCycle(c + 6);
    checkOutput("drop_last_rsp", rspValid, 4'b1000);
    checkOutput("drop_busy_rsp", busy, 1'b1);
    waitUntilCycle(c + 7);
    checkOutput("drop_busy_idle", busy, 1'b0);

    // Reset in the middle of two in-flight operations
    doReset();
    applyStimulus(4'b0011, 4'b0001, 1'b1);
    applyStimulus(4'b0011, 4'b0010, 1'b1);
    waitUntilCycle(cyc + 2);
    doReset();
    waitUntilCycle(cyc + 10);
    checkOutput("midrst_err", errSpurious, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);

    // Two req0 grants, drain, then a spurious adder valid
    reqVec = '{4, 1, 2, 3};
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    waitUntilCycle(cyc + 10);
    checkOutput("pre_spur_err", errSpurious, 1'b0);
    @(negedge clk);
    forceSpur = 1'b1;
    @(negedge clk);
    forceSpur = 1'b0;
    #1;
    checkOutput("spur_err_set", errSpurious, 1'b1);
    waitUntilCycle(cyc + 5);
    checkOutput("spur_err_sticky", errSpurious, 1'b1);
    checkOutput("spur_no_rsp", rspValid, '0);
`ifdef FP32_ARB_STATS_EN
    checkOutput("grant_cnt0", grantCnt[15:0], 64'(req0Grants));
    checkOutput("grant_cnt1", grantCnt[31:16], 64'd0);
    checkOutput("rsp_cnt", rspCnt, 64'd2);
`endif

    checkOutput("sb_drained", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
